ram_arbiter: RTL and testbench

Two-port arbiter that shares the SoC data RAM (four byte-lane synchronous RAMs, 2^13 bytes total) between the core load/store port (master 0) and the JTAG debug master (master 1). It grants at most one access per cycle with round-robin fairness and a debug lock for atomic sequences. It drives the byte-lane RAM strobes and routes the one-cycle-latency read response back to the owning master. It sits in `riscv_soc` between `riscv` / the JTAG debug module and `ram`.

---
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the byte-lane data RAM between the core (m0) and debug (m1) masters,
// with a debug lock for atomic sequences and one-cycle read-response routing.
module ram_arbiter #(
    parameter int unsigned RAM_AW = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [3:0]        m0_be,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [3:0]        m1_be,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic last_grant_q, last_grant_d;
    logic lock_q, lock_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_owner_q, resp_owner_d;
    logic resp_is_read_q, resp_is_read_d;
    logic lock_active;

    // Address bits outside the word index are aliased away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:RAM_AW+2], m0_addr[1:0],
                                m1_addr[31:RAM_AW+2], m1_addr[1:0]};

    // Lock only binds while m1 keeps m1_lock high; the release cycle arbitrates normally.
    assign lock_active = lock_q & m1_lock;

    always_comb begin
        m0_gnt         = 1'b0;
        m1_gnt         = 1'b0;
        ram_en         = 1'b0;
        ram_we         = 4'b0000;
        ram_addr       = m0_addr[RAM_AW+1:2];
        ram_wdata      = m0_wdata;
        last_grant_d   = last_grant_q;
        lock_d         = lock_q;
        resp_valid_d   = 1'b0;
        resp_owner_d   = resp_owner_q;
        resp_is_read_d = resp_is_read_q;

        if (lock_active) begin
            m1_gnt = m1_req;
        end else begin
            case ({m0_req, m1_req})
                2'b10:   m0_gnt = 1'b1;
                2'b01:   m1_gnt = 1'b1;
                2'b11: begin
                    m0_gnt = last_grant_q;
                    m1_gnt = ~last_grant_q;
                end
                default: ;
            endcase
        end

        if (m1_gnt) begin
            ram_en         = 1'b1;
            ram_we         = m1_be & {4{m1_we}};
            ram_addr       = m1_addr[RAM_AW+1:2];
            ram_wdata      = m1_wdata;
            last_grant_d   = 1'b1;
            resp_valid_d   = 1'b1;
            resp_owner_d   = 1'b1;
            resp_is_read_d = ~m1_we;
        end else if (m0_gnt) begin
            ram_en         = 1'b1;
            ram_we         = m0_be & {4{m0_we}};
            last_grant_d   = 1'b0;
            resp_valid_d   = 1'b1;
            resp_owner_d   = 1'b0;
            resp_is_read_d = ~m0_we;
        end

        if (m1_gnt && m1_lock) begin
            lock_d = 1'b1;
        end else if (!m1_lock) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q   <= 1'b1;
            lock_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_owner_q   <= 1'b0;
            resp_is_read_q <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            lock_q         <= lock_d;
            resp_valid_q   <= resp_valid_d;
            resp_owner_q   <= resp_owner_d;
            resp_is_read_q <= resp_is_read_d;
        end
    end

    // Response routing: RAM data appears one cycle after the grant.
    assign m0_rvalid = resp_valid_q & ~resp_owner_q;
    assign m1_rvalid = resp_valid_q &  resp_owner_q;
    assign m0_rdata  = (m0_rvalid && resp_is_read_q) ? ram_rdata : 32'h0;
    assign m1_rdata  = (m1_rvalid && resp_is_read_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a write-first byte-lane RAM model behind it.
module tb_ram_arbiter;

    localparam int unsigned RAM_AW = 11;

    logic              clk = 1'b0;
    logic              rstn;
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0]       m0_addr, m0_wdata, m0_rdata;
    logic [3:0]        m0_be;
    logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [31:0]       m1_addr, m1_wdata, m1_rdata;
    logic [3:0]        m1_be;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Write-first byte-lane synchronous RAM.
    logic [7:0] mem [0:3][0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) begin
                    mem[i][ram_addr]   <= ram_wdata[8*i +: 8];
                    ram_rdata[8*i +: 8] <= ram_wdata[8*i +: 8];
                end else begin
                    ram_rdata[8*i +: 8] <= mem[i][ram_addr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m0_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wd;
    endtask

    task automatic m1_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wd; m1_lock = lock;
    endtask

    task automatic idle_all();
        m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b1;
        idle_all();
        #1 rstn = 1'b0;
        tick(); settle();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        rstn = 1'b1;

        // Write then read back on m0.
        tick(); m0_drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF); settle();
        chk("wr_m0_gnt", m0_gnt, 1);
        chk("wr_m1_gnt", m1_gnt, 0);
        chk("wr_ram_en", ram_en, 1);
        chk("wr_ram_we", ram_we, 4'hF);
        chk("wr_ram_addr", ram_addr, 32'h4);
        chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        chk("wr_m0_rvalid_early", m0_rvalid, 0);
        tick(); m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); settle();
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("wr_m0_rvalid", m0_rvalid, 1);
        chk("wr_m0_rdata_zero", m0_rdata, 0);
        tick(); idle_all(); settle();
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);
        chk("idle_ram_en", ram_en, 0);
        chk("idle_ram_we", ram_we, 0);

        // Aliased address above the RAM range.
        tick(); m0_drive(1'b1, 1'b0, 32'h0000_2010, 4'h0, 32'h0); settle();
        chk("alias_gnt", m0_gnt, 1);
        chk("alias_ram_addr", ram_addr, 32'h4);
        tick(); idle_all(); settle();
        chk("alias_rvalid", m0_rvalid, 1);
        chk("alias_rdata", m0_rdata, 32'hDEADBEEF);
        tick(); settle();
        chk("alias_rvalid_pulse", m0_rvalid, 0);

        // Byte-enable write on m1, then a zero-enable write that must not change anything.
        tick(); m1_drive(1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b0); settle();
        chk("be_fill_gnt", m1_gnt, 1);
        tick(); m1_drive(1'b1, 1'b1, 32'h20, 4'b0101, 32'h11223344, 1'b0); settle();
        chk("be_ram_we", ram_we, 4'b0101);
        chk("be_fill_rvalid", m1_rvalid, 1);
        tick(); m1_drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0); settle();
        chk("be_rd_gnt", m1_gnt, 1);
        tick(); m1_drive(1'b1, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0); settle();
        chk("be_rd_rvalid", m1_rvalid, 1);
        chk("be_rd_rdata", m1_rdata, 32'hFF22FF44);
        chk("be_rd_m0_rvalid", m0_rvalid, 0);
        chk("be0_gnt", m1_gnt, 1);
        chk("be0_ram_we", ram_we, 0);
        tick(); m1_drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0); settle();
        chk("be0_rvalid", m1_rvalid, 1);
        tick(); idle_all(); settle();
        chk("be0_rd_rdata", m1_rdata, 32'hFF22FF44);

        // Fresh reset, then continuous contention alternates starting with m0.
        rstn = 1'b0;
        tick(); rstn = 1'b1;
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            settle();
            chk($sformatf("rr_m0_gnt_%0d", k), m0_gnt, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_m1_gnt_%0d", k), m1_gnt, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_m0_rvalid_%0d", k), m0_rvalid, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_m1_rvalid_%0d", k), m1_rvalid, (k > 0 && k % 2 == 0) ? 1 : 0);
            if (k % 2 == 1) chk($sformatf("rr_m0_rdata_%0d", k), m0_rdata, 32'hDEADBEEF);
            if (k > 0 && k % 2 == 0) chk($sformatf("rr_m1_rdata_%0d", k), m1_rdata, 32'hFF22FF44);
        end
        tick(); idle_all(); settle();
        chk("rr_tail_m1_rvalid", m1_rvalid, 1);
        chk("rr_tail_m1_rdata", m1_rdata, 32'hFF22FF44);
        chk("rr_tail_m0_rvalid", m0_rvalid, 0);

        // Lock: m1 takes ownership alone, then holds it against a waiting m0.
        tick(); m1_drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1); settle();
        chk("lk_first_m1_gnt", m1_gnt, 1);
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); settle();
            chk($sformatf("lk_m0_gnt_%0d", k), m0_gnt, 0);
            chk($sformatf("lk_m1_gnt_%0d", k), m1_gnt, 1);
        end
        // Lock drops with m1 still requesting: m0 wins alternation.
        tick(); m1_lock = 1'b0; settle();
        chk("unlk_m0_gnt", m0_gnt, 1);
        chk("unlk_m1_gnt", m1_gnt, 0);
        tick(); m0_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); settle();
        chk("unlk_m1_next", m1_gnt, 1);
        chk("unlk_m0_rdata", m0_rdata, 32'hDEADBEEF);
        // Lock drops with m1 idle: m0 granted at once.
        tick(); m1_lock = 1'b1; settle();
        chk("lk2_m1_gnt", m1_gnt, 1);
        tick(); m1_drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); settle();
        chk("lk2_m0_gnt", m0_gnt, 1);
        // m1_lock without an m1 grant must not lock m0 out.
        tick(); m1_lock = 1'b1; settle();
        chk("nolk_m0_gnt_a", m0_gnt, 1);
        tick(); settle();
        chk("nolk_m0_gnt_b", m0_gnt, 1);

        // Reset mid-transaction drops the pending response.
        tick(); m1_lock = 1'b0; m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0); settle();
        chk("mr_m0_gnt", m0_gnt, 1);
        #2 rstn = 1'b0;
        idle_all();
        #1;
        chk("mr_in_rst_ram_en", ram_en, 0);
        chk("mr_in_rst_rvalid", m0_rvalid, 0);
        tick();
        chk("mr_no_rvalid", m0_rvalid, 0);
        chk("mr_no_rdata", m0_rdata, 0);
        chk("mr_m1_rvalid", m1_rvalid, 0);
        chk("mr_ram_we", ram_we, 0);
        rstn = 1'b1;
        tick();
        m0_drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        m1_drive(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0); settle();
        chk("mr_after_m0_gnt", m0_gnt, 1);
        chk("mr_after_m1_gnt", m1_gnt, 0);
        tick(); idle_all(); settle();
        chk("mr_after_rvalid", m0_rvalid, 1);
        chk("mr_after_rdata", m0_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
